// File: rtl/sipo_packer.sv
// sipo_packer: serial-in/parallel-out word packer with valid/ready on both sides
module sipo_packer #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 17,
  parameter bit MSW_FIRST = 1'b1,
  localparam int CNT_W = $clog2(DEPTH+1)
)(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DEPTH*WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]       out_count,
  output logic                   out_last
);
  typedef enum logic {FILL, HOLD} state_t;
  state_t state;
  logic [CNT_W-1:0] cnt, wslot;
  logic [DEPTH*WIDTH-1:0] nxt;
  logic accept, drain, close;
  assign in_ready = (state == FILL) || out_ready;
  assign accept = in_valid && in_ready;
  assign drain = out_valid && out_ready;
  assign wslot = drain ? '0 : cnt;
  assign close = accept && (in_last || wslot == CNT_W'(DEPTH-1));
  // next buffer: zeroed on drain, then the accepted word dropped into its slot
  always_comb begin
    nxt = drain ? '0 : out_data;
    for (int k = 0; k < DEPTH; k++)
      if (accept && wslot == CNT_W'(k))
        nxt[(MSW_FIRST ? DEPTH-1-k : k)*WIDTH +: WIDTH] = in_data;
  end
  // FILL/HOLD control with registered block outputs; clear behaves like reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILL;
      cnt <= '0;
      out_data <= '0;
      out_valid <= 1'b0;
      out_count <= '0;
      out_last <= 1'b0;
    end else if (clear) begin
      state <= FILL;
      cnt <= '0;
      out_data <= '0;
      out_valid <= 1'b0;
      out_count <= '0;
      out_last <= 1'b0;
    end else begin
      if (accept || drain) out_data <= nxt;
      if (accept) cnt <= wslot + 1'b1;
      else if (drain) cnt <= '0;
      if (close) begin
        state <= HOLD;
        out_valid <= 1'b1;
        out_count <= wslot + 1'b1;
        out_last <= in_last;
      end else if (drain) begin
        state <= FILL;
        out_valid <= 1'b0;
        out_count <= '0;
        out_last <= 1'b0;
      end
    end
  end
endmodule
